// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice plus a registered carry, LSB first, one bit per clock.
// Optional signed-overflow output is enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic fa_sum(input logic x, input logic y, input logic c);
    return x ^ y ^ c;
  endfunction

  function automatic logic fa_carry(input logic x, input logic y, input logic c);
    return (x & y) | (x & c) | (y & c);
  endfunction

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_out_valid;
  logic             r_busy;
  logic             w_accept;
  logic             w_last;
  logic             w_bit_sum;
  logic             w_carry_next;
  logic [WIDTH-1:0] w_sum_shift;

  assign w_accept     = in_valid && (r_state == IDLE);
  assign w_last       = (r_cnt == CNT_LAST);
  assign w_bit_sum    = fa_sum(r_a_sh[0], r_b_sh[0], r_carry);
  assign w_carry_next = fa_carry(r_a_sh[0], r_b_sh[0], r_carry);

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign busy      = r_busy;

  // Partial-sum shifter; bit 0 of the shifted word is never needed, so only WIDTH-1 bits are stored.
  generate
    if (WIDTH == 1) begin : g_w1
      assign w_sum_shift = w_bit_sum;
    end else begin : g_wn
      logic [WIDTH-2:0] r_sum_sh;

      assign w_sum_shift = {w_bit_sum, r_sum_sh};

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_sum_sh <= {(WIDTH-1){1'b0}};
        end else if (w_accept) begin
          r_sum_sh <= {(WIDTH-1){1'b0}};
        end else if (r_state == RUN) begin
          r_sum_sh <= w_sum_shift[WIDTH-1:1];
        end else begin
          r_sum_sh <= r_sum_sh;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_state_next = RUN;
        end else begin
          w_state_next = IDLE;
        end
      end
      RUN: begin
        if (w_last) begin
          w_state_next = DONE;
        end else begin
          w_state_next = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_next = IDLE;
        end else begin
          w_state_next = DONE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Status flags follow the next state so they line up with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_out_valid <= (w_state_next == DONE);
      r_busy      <= (w_state_next == RUN);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_sh  <= {WIDTH{1'b0}};
      r_b_sh  <= {WIDTH{1'b0}};
      r_carry <= 1'b0;
      r_cnt   <= CNT_ZERO;
      r_sum   <= {WIDTH{1'b0}};
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_carry <= cin;
            r_cnt   <= CNT_ZERO;
          end else begin
            r_cnt   <= r_cnt;
          end
        end
        RUN: begin
          r_a_sh  <= r_a_sh >> 1;
          r_b_sh  <= r_b_sh >> 1;
          r_carry <= w_carry_next;
          r_cnt   <= r_cnt + CNT_ONE;
          if (w_last) begin
            r_sum  <= w_sum_shift;
            r_cout <= w_carry_next;
          end else begin
            r_sum  <= r_sum;
          end
        end
        DONE: begin
          r_sum  <= r_sum;
          r_cout <= r_cout;
        end
        default: begin
          r_cnt <= CNT_ZERO;
        end
      endcase
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic r_ovf;

  assign ovf = r_ovf;

  // On the last RUN cycle r_carry is the carry into the MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if ((r_state == RUN) && w_last) begin
      r_ovf <= r_carry ^ w_carry_next;
    end else begin
      r_ovf <= r_ovf;
    end
  end
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: WIDTH=8 directed vectors plus a WIDTH=1 instance.
module tb_serial_adder;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic         in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
  logic [W-1:0] a, b, sum;
  logic         v1_in_valid, v1_in_ready, v1_a, v1_b, v1_cin, v1_out_valid, v1_out_ready;
  logic         v1_sum, v1_cout, v1_busy;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf, v1_ovf;
`endif

  serial_adder #(.WIDTH(W)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1_in_valid), .in_ready(v1_in_ready),
    .a(v1_a), .b(v1_b), .cin(v1_cin), .out_valid(v1_out_valid), .out_ready(v1_out_ready),
    .sum(v1_sum), .cout(v1_cout), .busy(v1_busy)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(v1_ovf)
`endif
  );

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    int         rise;
  } exp_t;

  exp_t q8[$];
  exp_t q1[$];
  exp_t e8, e1;

  // Expected {cout, sum, ovf} for WIDTH=1, indexed by {a, b, cin}.
  localparam logic [2:0] EXP1 [8] = '{3'b000, 3'b011, 3'b010, 3'b100,
                                      3'b010, 3'b100, 3'b101, 3'b110};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic prev_v8 = 1'b0;
  always @(negedge clk) begin
    if (out_valid && !prev_v8) begin
      if (q8.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out_valid8: out_valid rose with no pending result (t=%0t)", $time);
      end else begin
        check("latency8", cyc, q8[0].rise);
      end
    end
    if (out_valid && out_ready && q8.size() > 0) begin
      e8 = q8.pop_front();
      check("sum8", {24'h0, sum}, {24'h0, e8.sum});
      check("cout8", {31'h0, cout}, {31'h0, e8.cout});
`ifdef SERIAL_ADDER_OVF_EN
      check("ovf8", {31'h0, ovf}, {31'h0, e8.ovf});
`endif
    end
    prev_v8 <= out_valid;
  end

  logic prev_v1 = 1'b0;
  always @(negedge clk) begin
    if (v1_out_valid && !prev_v1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out_valid1: out_valid rose with no pending result (t=%0t)", $time);
      end else begin
        check("latency1", cyc, q1[0].rise);
      end
    end
    if (v1_out_valid && v1_out_ready && q1.size() > 0) begin
      e1 = q1.pop_front();
      check("sum1", {31'h0, v1_sum}, {31'h0, e1.sum[0]});
      check("cout1", {31'h0, v1_cout}, {31'h0, e1.cout});
`ifdef SERIAL_ADDER_OVF_EN
      check("ovf1", {31'h0, v1_ovf}, {31'h0, e1.ovf});
`endif
    end
    prev_v1 <= v1_out_valid;
  end

  task automatic send8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                       input logic [7:0] es, input logic ec, input logic eo, output int t_acc);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #2; n++;
    end
    t_acc = -1;
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL in_ready_timeout8: in_ready stayed 0 for %0d cycles", n);
    end else begin
      a = ta; b = tb; cin = tc; in_valid = 1'b1;
      @(posedge clk); #2;
      in_valid = 1'b0;
      t_acc = cyc;
      q8.push_back('{es, ec, eo, cyc + W});
      a = ~ta; b = ~tb; cin = ~tc;
      check("busy_after_accept8", {31'h0, busy}, 32'h1);
    end
  endtask

  task automatic send1(input int idx);
    int n = 0;
    logic [2:0] ev;
    logic [2:0] iv;
    ev = EXP1[idx];
    iv = idx[2:0];
    while (!v1_in_ready && n < 100) begin
      @(posedge clk); #2; n++;
    end
    if (!v1_in_ready) begin
      checks++; errors++;
      $display("FAIL in_ready_timeout1: in_ready stayed 0 for %0d cycles", n);
    end else begin
      v1_a = iv[2]; v1_b = iv[1]; v1_cin = iv[0]; v1_in_valid = 1'b1;
      @(posedge clk); #2;
      v1_in_valid = 1'b0;
      q1.push_back('{{7'h0, ev[1]}, ev[2], ev[0], cyc + 1});
      v1_a = ~iv[2]; v1_b = ~iv[1]; v1_cin = ~iv[0];
    end
  endtask

  task automatic drain8();
    int n = 0;
    while (q8.size() != 0 && n < 200) begin
      @(posedge clk); #2; n++;
    end
    check("drain8", q8.size(), 32'h0);
  endtask

  task automatic drain1();
    int n = 0;
    while (q1.size() != 0 && n < 200) begin
      @(posedge clk); #2; n++;
    end
    check("drain1", q1.size(), 32'h0);
  endtask

  initial begin
    int t1, t2, n;
    logic seen;
    in_valid = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0; out_ready = 1'b1;
    v1_in_valid = 1'b0; v1_a = 1'b0; v1_b = 1'b0; v1_cin = 1'b0; v1_out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_sum", {24'h0, sum}, 32'h0);
    check("rst_cout", {31'h0, cout}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #2;
    check("in_ready_after_reset", {31'h0, in_ready}, 32'h1);

    // Zero, wrap-around, back-to-back spacing, signed overflow cases.
    send8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, t1);
    send8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, t2);
    check("throughput", t2, t1 + W + 2);
    send8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, t1);
    send8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, t1);
    send8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, t1);
    drain8();

    // Back-pressure: result held, in_valid ignored while DONE.
    out_ready = 1'b0;
    send8(8'h5A, 8'h33, 1'b1, 8'h8E, 1'b0, 1'b1, t1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #2; n++;
    end
    check("out_valid_rise_bp", {31'h0, out_valid}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      check("hold_sum", {24'h0, sum}, 32'h8E);
      check("hold_cout", {31'h0, cout}, 32'h0);
      check("hold_in_ready", {31'h0, in_ready}, 32'h0);
      check("hold_busy", {31'h0, busy}, 32'h0);
      in_valid = ~in_valid; a = 8'hC3; b = 8'h3C; cin = 1'b1;
      @(posedge clk); #2;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain8();
    @(posedge clk); #2;
    check("in_ready_after_bp", {31'h0, in_ready}, 32'h1);

    // Reset in the middle of RUN discards the operation.
    a = 8'hAA; b = 8'h55; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("busy_before_abort", {31'h0, busy}, 32'h1);
    rst = 1'b1;
    #1;
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_out_valid", {31'h0, out_valid}, 32'h0);
    @(posedge clk); #2;
    rst = 1'b0;
    check("abort_in_ready", {31'h0, in_ready}, 32'h1);
    seen = 1'b0;
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk); #2;
      seen = seen | out_valid | busy;
    end
    check("no_result_after_abort", {31'h0, seen}, 32'h0);
    send8(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, t1);
    drain8();

    // WIDTH=1: all full-adder input combinations.
    for (int i = 0; i < 8; i++) begin
      send1(i);
    end
    drain1();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
